// File: rtl/sprite_layer_mixer.sv
// Per-pixel sprite compositor: fixed-priority layer select over background,
// plus per-frame own-craft overlap counting published at v_sync fall.
module sprite_layer_mixer #(
  parameter int N_LAYERS = 4,
  parameter int RGB_W    = 12,
  parameter int CNT_W    = 8,
  localparam int SEL_W   = $clog2(N_LAYERS) + 1
) (
  input  logic                      clk_vga,
  input  logic                      rst,
  input  logic                      v_sync_i,
  input  logic                      disp_en_i,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb_i,
  input  logic [N_LAYERS-1:0]       layer_alpha_i,
  input  logic [RGB_W-1:0]          bg_rgb_i,
  input  logic                      hit_ack_i,
  output logic [RGB_W-1:0]          rgb_o,
  output logic [SEL_W-1:0]          layer_sel_o,
  output logic [CNT_W-1:0]          frame_hits_o,
  output logic                      frame_done_o,
  output logic                      hit_o
);

  typedef enum logic [1:0] {WAIT_FRAME, ACTIVE, PUBLISH} state_t;

  state_t                    state_q, state_d;
  logic [N_LAYERS*RGB_W-1:0] rgb_s1;
  logic [N_LAYERS-1:0]       alpha_s1;
  logic [RGB_W-1:0]          bg_s1;
  logic                      de_s1;
  logic                      valid_s1;
  logic                      vs_meta, vs_sync, vs_prev;
  logic                      vs_rise, vs_fall;
  logic [CNT_W-1:0]          counter, cnt_plus;
  logic                      pix_en, hit_pix, found;
  logic [RGB_W-1:0]          win_rgb;
  logic [SEL_W-1:0]          win_sel;

  // Stage 1: capture the layer inputs and the sync sampler
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      rgb_s1   <= '0;
      alpha_s1 <= '0;
      bg_s1    <= '0;
      de_s1    <= 1'b0;
      valid_s1 <= 1'b0;
      vs_meta  <= 1'b1;
      vs_sync  <= 1'b1;
      vs_prev  <= 1'b1;
    end else begin
      rgb_s1   <= layer_rgb_i;
      alpha_s1 <= layer_alpha_i;
      bg_s1    <= bg_rgb_i;
      de_s1    <= disp_en_i;
      valid_s1 <= 1'b1;
      vs_meta  <= v_sync_i;
      vs_sync  <= vs_meta;
      vs_prev  <= vs_sync;
    end
  end

  assign pix_en  = de_s1 & valid_s1;
  assign vs_rise = vs_sync & ~vs_prev;
  assign vs_fall = ~vs_sync & vs_prev;
  assign hit_pix = pix_en & alpha_s1[0] & (|alpha_s1[N_LAYERS-1:1]);
  assign cnt_plus = (hit_pix && counter != '1) ? counter + 1'b1 : counter;

  // Lowest opaque index wins; blanking overrides everything
  always_comb begin
    win_rgb = bg_s1;
    win_sel = SEL_W'(N_LAYERS);
    found   = 1'b0;
    for (int unsigned k = 0; k < N_LAYERS; k++) begin
      if (alpha_s1[k] && !found) begin
        win_rgb = rgb_s1[k*RGB_W +: RGB_W];
        win_sel = SEL_W'(k);
        found   = 1'b1;
      end
    end
    if (!pix_en) begin
      win_rgb = '0;
      win_sel = SEL_W'(N_LAYERS);
    end
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      rgb_o       <= '0;
      layer_sel_o <= SEL_W'(N_LAYERS);
    end else begin
      rgb_o       <= win_rgb;
      layer_sel_o <= win_sel;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_FRAME: if (vs_rise) state_d = ACTIVE;
      ACTIVE:     if (vs_fall) state_d = PUBLISH;
      PUBLISH:    state_d = WAIT_FRAME;
      default:    state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) state_q <= WAIT_FRAME;
    else     state_q <= state_d;
  end

  // Publish uses cnt_plus so a hit in the PUBLISH cycle itself is included
  always_ff @(posedge clk_vga or posedge rst) begin
    if (rst) begin
      counter      <= '0;
      frame_hits_o <= '0;
      frame_done_o <= 1'b0;
      hit_o        <= 1'b0;
    end else begin
      if (state_q == WAIT_FRAME && vs_rise) counter <= '0;
      else if (state_q == ACTIVE)           counter <= cnt_plus;
      frame_done_o <= (state_q == PUBLISH);
      if (state_q == PUBLISH) frame_hits_o <= cnt_plus;
      if (state_q == PUBLISH && cnt_plus != '0) hit_o <= 1'b1;
      else if (hit_ack_i)                       hit_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_layer_mixer.sv
// Bench for sprite_layer_mixer: per-cycle comparison against a behavioural
// frame/pixel model, plus directed scenarios with literal expectations.
module tb_sprite_layer_mixer;
  localparam int N = 4;
  localparam int W = 12;
  localparam int C = 8;
  localparam int SMAX = (1 << C) - 1;

  logic             clk_vga = 1'b0;
  logic             rst;
  logic             v_sync_i, disp_en_i, hit_ack_i;
  logic [N*W-1:0]   layer_rgb_i;
  logic [N-1:0]     layer_alpha_i;
  logic [W-1:0]     bg_rgb_i;
  logic [W-1:0]     rgb_o;
  logic [2:0]       layer_sel_o;
  logic [C-1:0]     frame_hits_o;
  logic             frame_done_o, hit_o;

  sprite_layer_mixer #(.N_LAYERS(N), .RGB_W(W), .CNT_W(C)) dut (
    .clk_vga(clk_vga), .rst(rst), .v_sync_i(v_sync_i), .disp_en_i(disp_en_i),
    .layer_rgb_i(layer_rgb_i), .layer_alpha_i(layer_alpha_i), .bg_rgb_i(bg_rgb_i),
    .hit_ack_i(hit_ack_i), .rgb_o(rgb_o), .layer_sel_o(layer_sel_o),
    .frame_hits_o(frame_hits_o), .frame_done_o(frame_done_o), .hit_o(hit_o)
  );

  always #5 clk_vga = ~clk_vga;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pixels seen one edge ago, sync seen three edges ago.
  logic [N*W-1:0] m_rgb;
  logic [N-1:0]   m_alpha;
  logic [W-1:0]   m_bg;
  logic           m_de;
  logic [2:0]     vhist;   // [0] newest sample
  int             m_mode;  // 0 idle between frames, 1 counting, 2 publishing
  int             m_cnt, pub, e_rgb, e_sel, e_hits;
  bit             e_done, e_hit, hp, rise, fall;

  always @(posedge clk_vga) begin
    if (rst) begin
      m_rgb = '0; m_alpha = '0; m_bg = '0; m_de = 0; vhist = 3'b111;
      m_mode = 0; m_cnt = 0; e_rgb = 0; e_sel = N; e_hits = 0; e_done = 0; e_hit = 0;
    end else begin
      hp   = m_de && m_alpha[0] && (m_alpha[N-1:1] != 0);
      rise = vhist[1] && !vhist[2];
      fall = !vhist[1] && vhist[2];
      e_done = (m_mode == 2);
      pub = (m_cnt + hp > SMAX) ? SMAX : m_cnt + hp;
      if (m_mode == 2) e_hits = pub;
      if (m_mode == 2 && pub != 0) e_hit = 1;
      else if (hit_ack_i) e_hit = 0;
      case (m_mode)
        0: if (rise) begin m_cnt = 0; m_mode = 1; end
        1: begin m_cnt = pub; if (fall) m_mode = 2; end
        default: m_mode = 0;
      endcase
      e_rgb = 0; e_sel = N;
      if (m_de) begin
        e_rgb = m_bg;
        for (int k = N - 1; k >= 0; k--)
          if (m_alpha[k]) begin e_rgb = m_rgb[k*W +: W]; e_sel = k; end
      end
      m_rgb = layer_rgb_i; m_alpha = layer_alpha_i; m_bg = bg_rgb_i; m_de = disp_en_i;
      vhist = {vhist[1:0], v_sync_i};
    end
    #2;
    chk("rgb", rgb_o, e_rgb);
    chk("sel", layer_sel_o, e_sel);
    chk("frame_hits", frame_hits_o, e_hits);
    chk("frame_done", frame_done_o, e_done);
    chk("hit", hit_o, e_hit);
    if (frame_done_o) done_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_vga);
      disp_en_i = 0; layer_alpha_i = '0; hit_ack_i = 0;
    end
  endtask

  task automatic pix(input logic [N-1:0] a, input int n);
    repeat (n) begin
      @(negedge clk_vga);
      disp_en_i = 1; layer_alpha_i = a;
      layer_rgb_i = {$urandom, $urandom};
      bg_rgb_i = W'($urandom);
    end
  endtask

  task automatic do_frame(input int ov, input int solo, input bit ack_pub);
    @(negedge clk_vga); v_sync_i = 1;
    idle(4);
    pix(4'b0011, ov);
    pix(4'b0001, solo);
    idle(4);
    @(negedge clk_vga); v_sync_i = 0;
    idle(2);
    @(negedge clk_vga); hit_ack_i = ack_pub;
    idle(5);
  endtask

  task automatic show(input logic [N*W-1:0] c, input logic [N-1:0] a,
                      input logic [W-1:0] bg, input bit de);
    @(negedge clk_vga);
    layer_rgb_i = c; layer_alpha_i = a; bg_rgb_i = bg; disp_en_i = de;
    repeat (2) @(posedge clk_vga);
    #3;
  endtask

  int d0, vs_left;
  logic [N*W-1:0] cols;

  initial begin
    rst = 1; v_sync_i = 0; disp_en_i = 0; hit_ack_i = 0;
    layer_rgb_i = '0; layer_alpha_i = '0; bg_rgb_i = '0;
    repeat (3) @(negedge clk_vga);
    rst = 0; #1;
    chk("reset_rgb", rgb_o, 0);
    chk("reset_sel", layer_sel_o, 4);
    chk("reset_hits", frame_hits_o, 0);
    chk("reset_done", frame_done_o, 0);
    chk("reset_hit", hit_o, 0);

    cols = {12'hFFF, 12'h00F, 12'h0F0, 12'hF00};
    show(cols, 4'b1111, 12'h123, 1);
    chk("prio_all_rgb", rgb_o, 'hF00); chk("prio_all_sel", layer_sel_o, 0);
    show(cols, 4'b1110, 12'h123, 1);
    chk("prio_l1_rgb", rgb_o, 'h0F0); chk("prio_l1_sel", layer_sel_o, 1);
    show(cols, 4'b0000, 12'h123, 1);
    chk("bg_rgb", rgb_o, 'h123); chk("bg_sel", layer_sel_o, 4);
    show(cols, 4'b0000, 12'h123, 0);
    chk("blank_rgb", rgb_o, 0); chk("blank_sel", layer_sel_o, 4);
    idle(2);

    d0 = done_cnt;
    do_frame(37, 10, 0);
    chk("ov37_hits", frame_hits_o, 37); chk("ov37_hit", hit_o, 1);
    chk("ov37_done_pulses", done_cnt - d0, 1);

    do_frame(300, 0, 0);
    chk("sat_hits", frame_hits_o, 255);
    do_frame(0, 0, 0);
    chk("zero_hits", frame_hits_o, 0); chk("zero_hit_sticky", hit_o, 1);
    @(negedge clk_vga); hit_ack_i = 1;
    @(negedge clk_vga); hit_ack_i = 0;
    chk("ack_clear", hit_o, 0);

    do_frame(5, 2, 1);
    chk("collide_hits", frame_hits_o, 5); chk("collide_set_wins", hit_o, 1);

    @(negedge clk_vga); v_sync_i = 1;
    idle(4);
    pix(4'b1001, 20);
    idle(2);
    @(negedge clk_vga); rst = 1; #1;
    chk("rstmid_rgb", rgb_o, 0); chk("rstmid_sel", layer_sel_o, 4);
    chk("rstmid_hits", frame_hits_o, 0); chk("rstmid_hit", hit_o, 0);
    @(negedge clk_vga); rst = 0;
    d0 = done_cnt;
    idle(3);
    @(negedge clk_vga); v_sync_i = 0;
    idle(8);
    chk("rstmid_no_publish", done_cnt - d0, 0);
    do_frame(7, 3, 0);
    chk("rstmid_next_hits", frame_hits_o, 7);
    chk("rstmid_next_done", done_cnt - d0, 1);

    vs_left = 80;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_vga);
      if (--vs_left <= 0) begin
        v_sync_i = ~v_sync_i;
        vs_left = v_sync_i ? $urandom_range(150, 60) : $urandom_range(8, 3);
      end
      disp_en_i = ($urandom_range(3, 0) != 0);
      layer_alpha_i = N'($urandom) & N'($urandom | 32'h1);
      layer_rgb_i = {$urandom, $urandom};
      bg_rgb_i = W'($urandom);
      hit_ack_i = ($urandom_range(15, 0) == 0);
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
